// File: rtl/serial_txrx_link_pkg.sv
// Shared types and sizes for the serial link.
// Word width, bit-counter width, TX/RX state enums.
package serial_txrx_link_pkg;

    localparam int DATA_W = 55;
    localparam int CNT_W  = 6;

    // Counter value at which the last data bit is handled.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic {
        RX_IDLE,
        RX_DATA
    } rx_state_e;

endpackage

// File: rtl/serial_txrx_link_if.sv
// Parallel-side handshake bundle of the serial link.
// master: user side (TX request, RX consumer); slave: the link.
interface serial_txrx_link_if;
    import serial_txrx_link_pkg::*;

    logic [DATA_W-1:0] TX_Data;
    logic              TX_Data_Valid;
    logic              TX_Ready;
    logic              RX_Ready;
    logic [DATA_W-1:0] RX_Data;
    logic              RX_Data_Valid;

    modport master (
        output TX_Data,
        output TX_Data_Valid,
        output RX_Ready,
        input  TX_Ready,
        input  RX_Data,
        input  RX_Data_Valid
    );

    modport slave (
        input  TX_Data,
        input  TX_Data_Valid,
        input  RX_Ready,
        output TX_Ready,
        output RX_Data,
        output RX_Data_Valid
    );

endinterface

// File: rtl/serial_rx_deser.sv
// Receive deserializer: waits for a start bit, assembles DATA_W bits.
// Ports: clk, rst, s_in (line), rx_data (last full word), rx_avail.
module serial_rx_deser
    import serial_txrx_link_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              s_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_avail
);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              avail_q, avail_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        data_d  = data_q;
        avail_d = avail_q;
        unique case (state_q)
            RX_IDLE: begin
                if (s_in) begin
                    state_d = RX_DATA;
                    cnt_d   = '0;
                    avail_d = 1'b0;
                end
            end
            RX_DATA: begin
                asm_d[cnt_q] = s_in;
                if (cnt_q == CNT_LAST) begin
                    // Publish only the complete word.
                    data_d  = asm_d;
                    avail_d = 1'b1;
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
            data_q  <= '0;
            avail_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            avail_q <= avail_d;
        end
    end

    assign rx_data  = data_q;
    assign rx_avail = avail_q;

endmodule

// File: rtl/serial_txrx_link.sv
// Serial link: TX serializer (start, DATA_W bits LSB first, stop) + RX.
// Ports: Clk_S, Rst, link (handshake bundle), S_Data_Out, S_Data_In.
module serial_txrx_link
    import serial_txrx_link_pkg::*;
(
    input  logic               Clk_S,
    input  logic               Rst,
    serial_txrx_link_if.slave  link,
    output logic               S_Data_Out,
    input  logic               S_Data_In
);

    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              valid_prev_q, valid_prev_d;
    logic              ready_q, ready_d;
    logic              sdo_q, sdo_d;
    logic              tx_rise;

    logic [DATA_W-1:0] rx_data;
    logic              rx_avail;

    assign tx_rise = link.TX_Data_Valid && !valid_prev_q;

    // Outputs are registered from the next state so that
    // reset forces them low on the same edge.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        ready_d      = 1'b0;
        sdo_d        = 1'b0;
        valid_prev_d = link.TX_Data_Valid;
        unique case (state_q)
            TX_IDLE: begin
                if (tx_rise) begin
                    shift_d = link.TX_Data;
                    state_d = TX_START;
                    sdo_d   = 1'b1;
                end else begin
                    ready_d = 1'b1;
                end
            end
            TX_START: begin
                state_d = TX_DATA;
                cnt_d   = '0;
                sdo_d   = shift_q[0];
                shift_d = shift_q >> 1;
            end
            TX_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = TX_STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    sdo_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            TX_STOP: begin
                state_d = TX_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk_S) begin
        if (Rst) begin
            state_q      <= TX_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            // Set so a Valid held through reset is not an edge.
            valid_prev_q <= 1'b1;
            ready_q      <= 1'b0;
            sdo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            valid_prev_q <= valid_prev_d;
            ready_q      <= ready_d;
            sdo_q        <= sdo_d;
        end
    end

    serial_rx_deser u_rx (
        .clk      (Clk_S),
        .rst      (Rst),
        .s_in     (S_Data_In),
        .rx_data  (rx_data),
        .rx_avail (rx_avail)
    );

    assign S_Data_Out         = sdo_q;
    assign link.TX_Ready      = ready_q;
    assign link.RX_Data       = rx_data;
    assign link.RX_Data_Valid = rx_avail && link.RX_Ready;

endmodule

// File: tb/tb_serial_txrx_link.sv
// Loopback bench for serial_txrx_link with a frame-level reference model.
// Ports: none (top-level bench).
module tb_serial_txrx_link;
    import serial_txrx_link_pkg::*;

    logic Clk_S = 1'b0;
    logic Rst   = 1'b1;
    logic S_Data_Out;
    logic S_Data_In;

    int n_checks = 0;
    int n_fail   = 0;

    serial_txrx_link_if lnk ();

    assign S_Data_In = S_Data_Out;

    serial_txrx_link dut (
        .Clk_S      (Clk_S),
        .Rst        (Rst),
        .link       (lnk),
        .S_Data_Out (S_Data_Out),
        .S_Data_In  (S_Data_In)
    );

    always #5 Clk_S = ~Clk_S;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    // Line image of a frame: start 1, word LSB first, stop 0.
    function automatic logic [56:0] frame_of(input logic [54:0] w);
        return {1'b0, w, 1'b1};
    endfunction

    function automatic logic [54:0] rand_word();
        return 55'({$urandom(), $urandom()});
    endfunction

    task automatic start_frame(input logic [54:0] w);
        bit ok;
        ok = 0;
        lnk.TX_Data_Valid = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge Clk_S);
            if (lnk.TX_Ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL start_wait: TX_Ready=%b want 1", lnk.TX_Ready);
        end
        lnk.TX_Data       = w;
        lnk.TX_Data_Valid = 1'b1;
    endtask

    task automatic capture(input int hold,
                           output logic [56:0] bits,
                           output logic [56:0] rdy);
        for (int i = 0; i < 57; i++) begin
            @(negedge Clk_S);
            bits[i] = S_Data_Out;
            rdy[i]  = lnk.TX_Ready;
            if (hold > 0 && i == hold - 1)
                lnk.TX_Data_Valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        bit ok;
        bit quiet;
        Rst = 1'b1;
        lnk.TX_Data_Valid = 1'b1;
        lnk.RX_Ready = 1'b0;
        lnk.TX_Data = rand_word();
        repeat (3) @(negedge Clk_S);
        n_checks++;
        if (lnk.TX_Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_tx_ready: got %b want 0", lnk.TX_Ready);
        end
        n_checks++;
        if (S_Data_Out !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_sdo: got %b want 0", S_Data_Out);
        end
        n_checks++;
        if (lnk.RX_Data_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rx_valid: got %b want 0",
                     lnk.RX_Data_Valid);
        end
        n_checks++;
        if (lnk.RX_Data !== 55'd0) begin
            n_fail++;
            $display("FAIL rst_rx_data: got %h want 0", lnk.RX_Data);
        end
        Rst = 1'b0;
        ok = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk_S);
            if (lnk.TX_Ready === 1'b1) ok = 1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rst_release_ready: got %b want 1",
                     lnk.TX_Ready);
        end
        quiet = 1;
        repeat (70) begin
            @(negedge Clk_S);
            if (S_Data_Out !== 1'b0 || lnk.TX_Ready !== 1'b1)
                quiet = 0;
        end
        n_checks++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL rst_held_valid: line active=%b want 0",
                     !quiet);
        end
        n_checks++;
        if (lnk.RX_Data !== 55'd0) begin
            n_fail++;
            $display("FAIL rst_no_rx: got %h want 0", lnk.RX_Data);
        end
        lnk.TX_Data_Valid = 1'b0;
    endtask

    task automatic test_loopback_basic();
        logic [56:0] bits;
        logic [56:0] rdy;
        start_frame(55'd3);
        capture(4, bits, rdy);
        n_checks++;
        if (rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_ready_drop: got %b want 0", rdy[0]);
        end
        n_checks++;
        if (bits !== frame_of(55'd3)) begin
            n_fail++;
            $display("FAIL lb_wave: got %h want %h",
                     bits, frame_of(55'd3));
        end
        repeat (93) @(negedge Clk_S);
        n_checks++;
        if (lnk.TX_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lb_ready: got %b want 1", lnk.TX_Ready);
        end
        n_checks++;
        if (lnk.RX_Data !== 55'd3) begin
            n_fail++;
            $display("FAIL lb_rx_data: got %h want 3", lnk.RX_Data);
        end
        n_checks++;
        if (lnk.RX_Data_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_valid_gated: got %b want 0",
                     lnk.RX_Data_Valid);
        end
        lnk.RX_Ready = 1'b1;
        #1;
        n_checks++;
        if (lnk.RX_Data_Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL lb_valid: got %b want 1", lnk.RX_Data_Valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [56:0] bits;
        logic [56:0] rdy;
        logic [54:0] w;
        logic [54:0] w2;
        w = 55'h55AA55AA55AA55;
        lnk.RX_Ready = 1'b0;
        start_frame(w);
        capture(3, bits, rdy);
        n_checks++;
        if (bits !== frame_of(w)) begin
            n_fail++;
            $display("FAIL b2b_wave: got %h want %h", bits, frame_of(w));
        end
        repeat (240) @(negedge Clk_S);
        n_checks++;
        if (lnk.RX_Data !== w || lnk.RX_Data_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_rx: got %h/%b want %h/0",
                     lnk.RX_Data, lnk.RX_Data_Valid, w);
        end
        lnk.RX_Ready = 1'b1;
        #1;
        n_checks++;
        if (lnk.RX_Data_Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_valid: got %b want 1", lnk.RX_Data_Valid);
        end
        w2 = rand_word();
        start_frame(w2);
        @(negedge Clk_S);
        n_checks++;
        if (lnk.RX_Data_Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_pre_start: got %b want 1",
                     lnk.RX_Data_Valid);
        end
        @(negedge Clk_S);
        lnk.TX_Data_Valid = 1'b0;
        n_checks++;
        if (lnk.RX_Data_Valid !== 1'b0 || lnk.RX_Data !== w) begin
            n_fail++;
            $display("FAIL b2b_start_drop: got %b/%h want 0/%h",
                     lnk.RX_Data_Valid, lnk.RX_Data, w);
        end
        repeat (60) @(negedge Clk_S);
        n_checks++;
        if (lnk.RX_Data !== w2 || lnk.RX_Data_Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: got %h/%b want %h/1",
                     lnk.RX_Data, lnk.RX_Data_Valid, w2);
        end
    endtask

    task automatic test_valid_held();
        logic [56:0] bits;
        logic [56:0] rdy;
        logic [54:0] w;
        bit quiet;
        w = rand_word();
        start_frame(w);
        capture(0, bits, rdy);
        n_checks++;
        if (bits !== frame_of(w)) begin
            n_fail++;
            $display("FAIL held_wave: got %h want %h", bits, frame_of(w));
        end
        quiet = 1;
        repeat (80) begin
            @(negedge Clk_S);
            if (S_Data_Out !== 1'b0) quiet = 0;
        end
        n_checks++;
        if (!quiet || lnk.TX_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL held_one_frame: extra=%b ready=%b want 0/1",
                     !quiet, lnk.TX_Ready);
        end
        w = rand_word();
        start_frame(w);
        for (int i = 0; i < 57; i++) begin
            @(negedge Clk_S);
            bits[i] = S_Data_Out;
            if (i == 5) lnk.TX_Data_Valid = 1'b0;
            if (i == 20) begin
                lnk.TX_Data_Valid = 1'b1;
                lnk.TX_Data = ~w;
            end
        end
        n_checks++;
        if (bits !== frame_of(w)) begin
            n_fail++;
            $display("FAIL midframe_edge_wave: got %h want %h",
                     bits, frame_of(w));
        end
        quiet = 1;
        repeat (80) begin
            @(negedge Clk_S);
            if (S_Data_Out !== 1'b0) quiet = 0;
        end
        n_checks++;
        if (!quiet || lnk.RX_Data !== w) begin
            n_fail++;
            $display("FAIL midframe_edge_ignored: extra=%b rx=%h want 0/%h",
                     !quiet, lnk.RX_Data, w);
        end
        lnk.TX_Data_Valid = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [56:0] bits;
        logic [56:0] rdy;
        logic [54:0] w;
        lnk.RX_Ready = 1'b1;
        start_frame(rand_word());
        repeat (30) @(negedge Clk_S);
        Rst = 1'b1;
        @(negedge Clk_S);
        n_checks++;
        if (lnk.TX_Ready !== 1'b0 || S_Data_Out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_tx: ready=%b sdo=%b want 0/0",
                     lnk.TX_Ready, S_Data_Out);
        end
        n_checks++;
        if (lnk.RX_Data_Valid !== 1'b0 || lnk.RX_Data !== 55'd0) begin
            n_fail++;
            $display("FAIL mid_rst_rx: valid=%b data=%h want 0/0",
                     lnk.RX_Data_Valid, lnk.RX_Data);
        end
        Rst = 1'b0;
        lnk.TX_Data_Valid = 1'b0;
        repeat (3) @(negedge Clk_S);
        n_checks++;
        if (lnk.TX_Ready !== 1'b1 || S_Data_Out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_idle: ready=%b sdo=%b want 1/0",
                     lnk.TX_Ready, S_Data_Out);
        end
        w = rand_word();
        start_frame(w);
        capture(2, bits, rdy);
        n_checks++;
        if (bits !== frame_of(w)) begin
            n_fail++;
            $display("FAIL mid_rst_wave: got %h want %h",
                     bits, frame_of(w));
        end
        repeat (5) @(negedge Clk_S);
        n_checks++;
        if (lnk.RX_Data !== w || lnk.RX_Data_Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rst_rx_after: got %h/%b want %h/1",
                     lnk.RX_Data, lnk.RX_Data_Valid, w);
        end
    endtask

    // Random words with RX_Ready toggling during reception.
    task automatic test_random_frames();
        logic [56:0] bits;
        logic [54:0] w;
        logic [54:0] old;
        logic        rr;
        logic        exp_v;
        int          hold;
        old = lnk.RX_Data;
        for (int f = 0; f < 8; f++) begin
            w = rand_word();
            hold = $urandom_range(1, 20);
            start_frame(w);
            for (int i = 0; i < 57; i++) begin
                @(negedge Clk_S);
                bits[i] = S_Data_Out;
                if (i == hold - 1) lnk.TX_Data_Valid = 1'b0;
                rr = 1'($urandom_range(0, 1));
                lnk.RX_Ready = rr;
                #1;
                if (i <= 55) begin
                    // Old word is still flagged until RX sees the start bit.
                    exp_v = (i == 0) ? rr : 1'b0;
                    n_checks++;
                    if (lnk.RX_Data !== old ||
                        lnk.RX_Data_Valid !== exp_v) begin
                        n_fail++;
                        $display("FAIL rnd_rx_during f%0d i%0d: %h/%b want %h/%b",
                                 f, i, lnk.RX_Data, lnk.RX_Data_Valid,
                                 old, exp_v);
                    end
                end
            end
            n_checks++;
            if (bits !== frame_of(w)) begin
                n_fail++;
                $display("FAIL rnd_wave f%0d: got %h want %h",
                         f, bits, frame_of(w));
            end
            repeat (2) @(negedge Clk_S);
            rr = 1'($urandom_range(0, 1));
            lnk.RX_Ready = rr;
            #1;
            n_checks++;
            if (lnk.RX_Data !== w || lnk.RX_Data_Valid !== rr) begin
                n_fail++;
                $display("FAIL rnd_rx_done f%0d: got %h/%b want %h/%b",
                         f, lnk.RX_Data, lnk.RX_Data_Valid, w, rr);
            end
            old = w;
        end
    endtask

    initial begin
        lnk.TX_Data       = '0;
        lnk.TX_Data_Valid = 1'b0;
        lnk.RX_Ready      = 1'b0;
        test_reset();
        test_loopback_basic();
        test_back_to_back();
        test_valid_held();
        test_reset_midframe();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
